// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_t : fetch FSM states (BOOT, FETCH, FULL)
//   INSTR_BYTES   : address step between sequential instructions
//   NOP           : canonical no-op encoding (addi x0, x0, 0)
//   word_align    : clears the two byte-offset bits of an address
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FULL  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam logic [31:0] NOP         = 32'h0000_0013;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Prefetch queue: synchronous FIFO of {pc, instr} entries with flush.
// The head entry is held in its own register so the decode-facing outputs
// are registered and keep their last value while the queue is empty.
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush          : clears count and pointers (head register holds)
//   push/push_data : write one 64-bit entry (ignored when full)
//   pop            : retire the head entry (ignored when empty)
//   full, empty    : occupancy flags
//   count          : number of valid entries, 0..QUEUE_DEPTH
//   head_data      : registered head entry {pc, instr}
module instruction_fetch_unit_fetch_queue #(
    parameter int QUEUE_DEPTH = 4,
    parameter int PTR_W       = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [63:0]      push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count,
    output logic [63:0]      head_data
);

    localparam int                CNT_W     = PTR_W + 1;
    localparam logic [PTR_W:0]    DEPTH_CNT = CNT_W'(QUEUE_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1'b1);

    logic [63:0]      mem_r [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic [63:0]      head_r;

    logic             push_ok_s;
    logic             pop_ok_s;
    logic [PTR_W-1:0] rd_next_s;
    logic [PTR_W:0]   count_next_s;
    logic [63:0]      head_next_s;

    // Next pointer/count values and the entry that will sit at the head after this edge
    always_comb begin
        push_ok_s    = push && (count_r != DEPTH_CNT);
        pop_ok_s     = pop && (count_r != {CNT_W{1'b0}});
        rd_next_s    = pop_ok_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        count_next_s = count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        head_next_s  = head_r;
        if (flush) begin
            head_next_s = head_r;
        end else if (count_next_s != {CNT_W{1'b0}}) begin
            // The slot about to become head may be the one being written now
            if (push_ok_s && (wr_ptr_r == rd_next_s)) begin
                head_next_s = push_data;
            end else begin
                head_next_s = mem_r[rd_next_s];
            end
        end else begin
            head_next_s = head_r;
        end
    end

    // Storage, pointers, count and registered head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                mem_r[i] <= 64'd0;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            head_r   <= 64'd0;
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            head_r   <= head_next_s;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            rd_ptr_r <= rd_next_s;
            count_r  <= count_next_s;
            head_r   <= head_next_s;
        end
    end

    assign full      = (count_r == DEPTH_CNT);
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign head_data = head_r;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues sequential word-aligned reads to the MMU,
// buffers returned words in a prefetch queue and presents them to decode
// over a valid/ready handshake. A redirect flushes the queue, drops any
// response accepted in the same cycle and restarts fetch at the new PC.
//   clk, reset              : clock, asynchronous active-low reset
//   mem_addr/mem_ren        : fetch address and read request to the MMU
//   mem_wen/byte_select_vector : tied to read-only, full-word access
//   memReady/mem_dataout    : response valid strobe and instruction word
//   redirect_valid/redirect_pc : one-cycle flush-and-restart request
//   inst_valid/inst_ready   : decode handshake
//   inst_data/inst_pc       : head instruction word and its address
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 4,
    parameter int          PTR_W       = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_addr,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [3:0]  byte_select_vector,
    input  logic        memReady,
    input  logic [31:0] mem_dataout,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int             CNT_W     = PTR_W + 1;
    localparam logic [PTR_W:0] DEPTH_CNT = CNT_W'(QUEUE_DEPTH);

    fetch_state_t   state_r;
    fetch_state_t   state_next_s;
    logic [31:0]    pc_r;
    logic           mem_ren_s;
    logic           push_s;
    logic           pop_s;
    logic           full_s;
    logic           empty_s;
    logic [PTR_W:0] count_s;
    logic [PTR_W:0] count_after_s;
    logic [63:0]    head_s;

    // Queue control; a redirect suppresses both the response push and the decode pop
    always_comb begin
        push_s        = mem_ren_s && memReady && !redirect_valid && !full_s;
        pop_s         = !empty_s && inst_ready && !redirect_valid;
        count_after_s = count_s + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; occupancy after this edge decides FETCH versus FULL
    always_comb begin
        state_next_s = state_r;
        if (redirect_valid) begin
            state_next_s = ST_FETCH;
        end else begin
            case (state_r)
                ST_BOOT:  state_next_s = ST_FETCH;
                ST_FETCH: state_next_s = (count_after_s == DEPTH_CNT) ? ST_FULL : ST_FETCH;
                ST_FULL:  state_next_s = (count_after_s < DEPTH_CNT) ? ST_FETCH : ST_FULL;
                default:  state_next_s = ST_BOOT;
            endcase
        end
    end

    // FSM outputs: reads are requested only while fetching
    always_comb begin
        case (state_r)
            ST_FETCH: mem_ren_s = 1'b1;
            ST_BOOT:  mem_ren_s = 1'b0;
            ST_FULL:  mem_ren_s = 1'b0;
            default:  mem_ren_s = 1'b0;
        endcase
    end

    // Fetch PC: redirect wins, otherwise advance one word per accepted response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r <= word_align(RESET_PC);
        end else if (redirect_valid) begin
            pc_r <= word_align(redirect_pc);
        end else if (push_s) begin
            pc_r <= pc_r + INSTR_BYTES;
        end else begin
            pc_r <= pc_r;
        end
    end

    instruction_fetch_unit_fetch_queue #(
        .QUEUE_DEPTH (QUEUE_DEPTH),
        .PTR_W       (PTR_W)
    ) u_fetch_queue (
        .clk       (clk),
        .rst_n     (reset),
        .flush     (redirect_valid),
        .push      (push_s),
        .push_data ({pc_r, mem_dataout}),
        .pop       (pop_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (count_s),
        .head_data (head_s)
    );

    assign mem_addr           = pc_r;
    assign mem_ren            = mem_ren_s;
    assign mem_wen            = 1'b0;
    assign byte_select_vector = 4'b1111;
    assign inst_valid         = !empty_s;
    assign inst_pc            = head_s[63:32];
    assign inst_data          = head_s[31:0];

endmodule
